// File: rtl/day12_param_priority_encoder.sv
// day12_param_priority_encoder: registered NUM_REQ-way priority encoder holding each grant until ready_in (clk, reset async, req_in, ready_in -> valid_out, idx_out, onehot_out); define RR_MODE_EN for round-robin priority
module day12_param_priority_encoder #(
    parameter int NUM_REQ = 8,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic               ready_in,
    output logic               valid_out,
    output logic [IDX_W-1:0]   idx_out,
    output logic [NUM_REQ-1:0] onehot_out
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_nxt;
    logic valid_nxt, take, ack;
    logic [IDX_W-1:0] idx_nxt, win;
    logic [NUM_REQ-1:0] onehot_nxt;
    assign take = state == IDLE && |req_in;
    assign ack = state == HOLD && ready_in;
`ifdef RR_MODE_EN
    logic [IDX_W-1:0] ptr;
    always_comb begin
        int j;
        j = 0;
        win = '0;
        for (int d = NUM_REQ; d >= 1; d--) begin
            j = int'(ptr) + NUM_REQ - d;
            j = j >= NUM_REQ ? j - NUM_REQ : j;
            if (req_in[j]) win = IDX_W'(j);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr <= '0;
        else if (ack) ptr <= idx_out;
    end
`else
    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) if (req_in[i]) win = IDX_W'(i);
    end
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            valid_out  <= 1'b0;
            idx_out    <= '0;
            onehot_out <= '0;
        end else begin
            state      <= state_nxt;
            valid_out  <= valid_nxt;
            idx_out    <= idx_nxt;
            onehot_out <= onehot_nxt;
        end
    end
    always_comb begin
        state_nxt  = take ? HOLD : ack ? IDLE : state;
        valid_nxt  = take | (valid_out & ~ack);
        idx_nxt    = take ? win : idx_out;
        onehot_nxt = take ? NUM_REQ'(1) << win : ack ? '0 : onehot_out;
    end
endmodule

// File: tb/tb_day12_param_priority_encoder.sv
// tb_day12_param_priority_encoder: scoreboard bench for 8- and 5-wide encoders
module tb_day12_param_priority_encoder;
`ifdef RR_MODE_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef struct {int cyc; int idx; int oh;} ent_t;
    logic clk = 1'b0, reset;
    logic [7:0] req8, oh8;
    logic [2:0] idx8;
    logic ready8, valid8;
    logic [4:0] req5, oh5;
    logic [2:0] idx5;
    logic ready5, valid5;
    int cyc = 0, n = 0, errs = 0;
    ent_t q8[$], q5[$];
    ent_t e8, e5;
    logic pv8 = 1'b0, pv5 = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    day12_param_priority_encoder #(.NUM_REQ(8)) u8 (
        .clk(clk), .reset(reset), .req_in(req8), .ready_in(ready8),
        .valid_out(valid8), .idx_out(idx8), .onehot_out(oh8));
    day12_param_priority_encoder #(.NUM_REQ(5)) u5 (
        .clk(clk), .reset(reset), .req_in(req5), .ready_in(ready5),
        .valid_out(valid5), .idx_out(idx5), .onehot_out(oh5));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        if (!reset) begin
            if (valid8 && !pv8) begin
                if (q8.size() == 0) chk("g8_unexpected_valid", 32'(valid8), 0);
                else begin
                    e8 = q8.pop_front();
                    chk("g8_cycle", cyc, e8.cyc);
                    chk("g8_idx", 32'(idx8), e8.idx);
                    chk("g8_onehot", 32'(oh8), e8.oh);
                end
            end else if (valid8) begin
                chk("g8_hold_idx", 32'(idx8), e8.idx);
                chk("g8_hold_onehot", 32'(oh8), e8.oh);
            end else chk("g8_idle_onehot", 32'(oh8), 0);
        end
        pv8 = reset ? 1'b0 : valid8;
    end
    always @(negedge clk) begin
        if (!reset) begin
            if (valid5 && !pv5) begin
                if (q5.size() == 0) chk("g5_unexpected_valid", 32'(valid5), 0);
                else begin
                    e5 = q5.pop_front();
                    chk("g5_cycle", cyc, e5.cyc);
                    chk("g5_idx", 32'(idx5), e5.idx);
                    chk("g5_onehot", 32'(oh5), e5.oh);
                end
            end else if (valid5) begin
                chk("g5_hold_idx", 32'(idx5), e5.idx);
                chk("g5_hold_onehot", 32'(oh5), e5.oh);
            end else chk("g5_idle_onehot", 32'(oh5), 0);
        end
        pv5 = reset ? 1'b0 : valid5;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int x;
        reset = 1'b1; req8 = 8'hFF; ready8 = 1'b0; req5 = '0; ready5 = 1'b0;
        #2;
        chk("rst_valid8", 32'(valid8), 0); chk("rst_idx8", 32'(idx8), 0); chk("rst_onehot8", 32'(oh8), 0);
        chk("rst_valid5", 32'(valid5), 0); chk("rst_onehot5", 32'(oh5), 0);
        @(negedge clk);
        chk("rst_edge_valid8", 32'(valid8), 0); chk("rst_edge_onehot8", 32'(oh8), 0);
        reset = 1'b0; req8 = '0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_valid8", 32'(valid8), 0); chk("idle_idx8", 32'(idx8), 0);
        end
        req8 = 8'b0010_1100; q8.push_back('{cyc + 1, 5, 8'h20});
        @(negedge clk);
        req8 = 8'h80;
        repeat (2) @(negedge clk);
        ready8 = 1'b1; q8.push_back('{cyc + 2, 7, 8'h80});
        repeat (2) @(negedge clk);
        req8 = '0;
        @(negedge clk);
        req8 = 8'hFF; ready8 = 1'b0;
        q8.push_back('{cyc + 1, RR ? 6 : 7, RR ? 8'h40 : 8'h80});
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_valid8", 32'(valid8), 0); chk("async_onehot8", 32'(oh8), 0); chk("async_idx8", 32'(idx8), 0);
        @(negedge clk);
        reset = 1'b0; ready8 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            x = RR ? (15 - k) % 8 : 7;
            q8.push_back('{cyc + 1 + 2 * k, x, 1 << x});
        end
        repeat (17) @(negedge clk);
        req8 = '0;
        repeat (3) @(negedge clk);
        req5 = 5'b10001; ready5 = 1'b1; q5.push_back('{cyc + 1, 4, 5'b10000});
        @(negedge clk);
        req5 = '0;
        repeat (3) begin
            @(negedge clk);
            chk("zero_req_valid5", 32'(valid5), 0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; req5 = 5'h1F;
        for (int k = 0; k < 6; k++) begin
            x = RR ? (9 - k) % 5 : 4;
            q5.push_back('{cyc + 1 + 2 * k, x, 1 << x});
        end
        repeat (11) @(negedge clk);
        req5 = '0;
        repeat (4) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q5_drained", q5.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
